ofm_requant_packer: RTL and testbench
=====================================

# ofm_requant_packer

Downstream stage of the CNN convolution kernel. Consumes the 25-bit output-feature-map write stream (`O_wren`/`O_ram_addr`/`O_ram_din`), applies ReLU, right-shift requantisation and unsigned 8-bit saturation, then packs eight bytes into 64-bit words for the next layer's input RAM, which is 8 bytes wide. A small FIFO decouples it from a RAM write port that can stall. The upstream kernel has no backpressure, so FIFO overflow is reported, not prevented.

## Interface

Parameters:
- `IW`, 25: input data width; signed two's complement.
- `SHIFT`, 8: requantisation right-shift, 1..16.
- `FIFO_DEPTH`, 4: packed-word FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `O_wren` in 1: input sample valid; accepted unconditionally.
- `O_ram_addr` in 32: byte address of the sample in the output map.
- `O_ram_din` in IW: convolution result.
- `end_conv` in 1: one-cycle pulse from the kernel; starts the final flush.
- `P_wren` out 1: packed word valid (FIFO head).
- `P_ready` in 1: RAM accepts the word; a transfer occurs when `P_wren && P_ready`.
- `P_addr` out 32: word address, equal to `O_ram_addr >> 3`.
- `P_din` out 64: packed bytes; lane k is bits [8k+7:8k].
- `P_be` out 8: byte enables; bit k is 1 iff lane k was written.
- `overflow` out 1: sticky; set when a word is lost because the FIFO is full.
- `done` out 1: one-cycle pulse when the flush completes and the FIFO is empty.

## Operation

Requantisation is combinational on each accepted sample:
- If `O_ram_din` is negative, the result is 0 (ReLU).
- Otherwise `q = O_ram_din >> SHIFT`, with optional rounding (see Configuration).
- If `q > 255`, the result is 255; otherwise it is `q[7:0]`.

Pack register: `pk_data[63:0]`, `pk_be[7:0]`, `pk_addr[28:0]`. Lane is `O_ram_addr[2:0]`; word address is `O_ram_addr[31:3]`.

State machine:
- **EMPTY**
  - On `O_wren`: load `pk_addr`, write the lane, set its `pk_be` bit, go to FILL.
- **FILL**
  - On `O_wren` with the same word address: write the lane (a rewrite of a lane overwrites it) and set its `pk_be` bit.
  - If this makes `pk_be == 8'hFF`: push the word and go to EMPTY.
  - On `O_wren` with a different word address: push the current partial word; in the same cycle start a new word with the incoming sample and stay in FILL.
  - On `end_conv`: go to FLUSH.
- **FLUSH**
  - Push the pack register if `pk_be != 0`, then go to DRAIN.
- **DRAIN**
  - When the FIFO is empty, pulse `done` and go to EMPTY.
  - `O_wren` is ignored in FLUSH and DRAIN.

Simultaneous events:
- `O_wren` and `end_conv` in the same cycle: the sample is packed first, then the word is flushed.
- Push to a full FIFO:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the word is dropped and `overflow` is set.
- FIFO pointers wrap modulo `FIFO_DEPTH`; an extra pointer bit distinguishes full from empty.

## Timing

- Reset values:
  - `P_wren` = 0, `P_addr` = 0, `P_din` = 0, `P_be` = 0.
  - `overflow` = 0, `done` = 0.
  - State is EMPTY, FIFO is empty, pack register is cleared.
- Reset asserted mid-operation discards the pack register and FIFO contents immediately.
- Latency: a completing sample at posedge *n* produces `P_wren` = 1 after posedge *n+1*.
- `P_*` outputs are registered FIFO-head outputs. They stay stable while `P_wren && !P_ready`.
- Throughput: one sample per cycle in; one word per cycle out.
- `done` is high for exactly one cycle. It occurs at least 2 cycles after `end_conv`.

## Configuration

- `OFM_REQUANT_ROUND_EN` defined: `q = (O_ram_din + 2^(SHIFT-1)) >> SHIFT`, i.e. round half up. The sum is computed at IW+1 bits, so it cannot wrap.
- Not defined: `q = O_ram_din >> SHIFT`, i.e. truncation.

## Test plan

All scenarios use `SHIFT`=8 and `FIFO_DEPTH`=4.

1. Full word, rounding enabled: addresses 0..7, each with din=384, `P_ready`=1 → one transfer with `P_addr`=0, `P_din`=0x0202020202020202, `P_be`=0xFF. With the macro undefined, `P_din`=0x0101010101010101.
2. ReLU and saturation: addr 8 din=-1, addr 9 din=1048576, addr 10 din=512, then addr 24 din=256 → first word has `P_addr`=1, `P_be`=0x07, bytes {0x02, 0xFF, 0x00} in lanes 2,1,0. The second word, `P_addr`=3, is held in the pack register.
3. Flush: continue scenario 2 with an `end_conv` pulse → word with `P_addr`=3, `P_be`=0x01, lane0=0x01 is emitted, then `done` pulses once.
4. Backpressure: `P_ready`=0, five full words streamed → `overflow`=1 after the fifth push. Raising `P_ready` then yields exactly 4 words, in order, with stable outputs while stalled.
5. Simultaneous push and pop at full: FIFO full, `P_ready`=1 in the completing cycle → no overflow, and the word is delivered.
6. Reset mid-stream: drive `rst`=0 after 3 samples → all outputs are 0 immediately. After release, addresses 0..7 produce a single word with `P_be`=0xFF.

Source files
------------

// File: rtl/ofm_requant_packer.sv
// rtl/ofm_requant_packer.sv - ReLU/shift requantise OFM samples, pack 8 bytes per 64-bit word, FIFO to RAM port; optional rounding via OFM_REQUANT_ROUND_EN
module ofm_requant_packer #(
  parameter int IW         = 25,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          O_wren,
  input  logic [31:0]   O_ram_addr,
  input  logic [IW-1:0] O_ram_din,
  input  logic          end_conv,
  output logic          P_wren,
  input  logic          P_ready,
  output logic [31:0]   P_addr,
  output logic [63:0]   P_din,
  output logic [7:0]    P_be,
  output logic          overflow,
  output logic          done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FLUSH, S_DRAIN} state_t;

  state_t      state, state_nx;
  logic [63:0] pk_data, pk_data_nx;
  logic [7:0]  pk_be, pk_be_nx;
  logic [28:0] pk_addr, pk_addr_nx;
  logic        push;
  logic [63:0] push_data;
  logic [7:0]  push_be;
  logic [28:0] push_addr;
  logic        done_nx;

  logic [IW:0] rq_sum;
  logic [IW:0] rq_q;
  logic [7:0]  rq_byte;
  logic [2:0]  lane;
  logic [28:0] in_waddr;
  logic [63:0] lane_mask;
  logic [63:0] lane_data;
  logic [7:0]  lane_be;

  logic [63:0] mem_data [FIFO_DEPTH];
  logic [7:0]  mem_be   [FIFO_DEPTH];
  logic [28:0] mem_addr [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic        fifo_empty, fifo_full, pop, push_ok;
  logic [AW-1:0] head;
  logic        head_valid;

  assign lane      = O_ram_addr[2:0];
  assign in_waddr  = O_ram_addr[31:3];
  assign lane_mask = 64'hFF << {lane, 3'b000};
  assign lane_data = {56'd0, rq_byte} << {lane, 3'b000};
  assign lane_be   = 8'd1 << lane;

  // Requantise the incoming sample: ReLU, right shift (optionally rounded), clamp to 0..255
  always_comb begin
    rq_sum = {1'b0, O_ram_din};
`ifdef OFM_REQUANT_ROUND_EN
    rq_sum = rq_sum + ((IW+1)'(1) << (SHIFT-1));
`endif
    rq_q = rq_sum >> SHIFT;
    if (O_ram_din[IW-1])
      rq_byte = 8'd0;
    else if (rq_q > (IW+1)'(255))
      rq_byte = 8'hFF;
    else
      rq_byte = rq_q[7:0];
  end

  // Pack FSM next state: merge lanes, decide when a word leaves the pack register
  always_comb begin
    state_nx   = state;
    pk_data_nx = pk_data;
    pk_be_nx   = pk_be;
    pk_addr_nx = pk_addr;
    push       = 1'b0;
    push_data  = pk_data;
    push_be    = pk_be;
    push_addr  = pk_addr;
    done_nx    = 1'b0;
    case (state)
      S_EMPTY, S_FILL: begin
        if (O_wren) begin
          if (state == S_FILL && in_waddr == pk_addr) begin
            pk_data_nx = (pk_data & ~lane_mask) | lane_data;
            pk_be_nx   = pk_be | lane_be;
            if (pk_be_nx == 8'hFF) begin
              push       = 1'b1;
              push_data  = pk_data_nx;
              push_be    = 8'hFF;
              pk_data_nx = '0;
              pk_be_nx   = '0;
              state_nx   = S_EMPTY;
            end
          end else begin
            // a new word address displaces the partial word in the pack register
            push       = (state == S_FILL);
            pk_addr_nx = in_waddr;
            pk_data_nx = lane_data;
            pk_be_nx   = lane_be;
            state_nx   = S_FILL;
          end
        end
        // the sample of this cycle is already merged above, so the flush sees it
        if (end_conv) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        push       = (pk_be != 8'd0);
        pk_data_nx = '0;
        pk_be_nx   = '0;
        state_nx   = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done_nx  = 1'b1;
          state_nx = S_EMPTY;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  assign pop        = P_wren && P_ready;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = push && (!fifo_full || pop);
  assign rd_ptr_nx  = rd_ptr + {{AW{1'b0}}, pop};
  assign head       = rd_ptr_nx[AW-1:0];
  // only words stored before this edge are eligible, which gives the extra output-stage cycle
  assign head_valid = (wr_ptr != rd_ptr_nx);

  // State, pack register, FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_EMPTY;
      pk_data  <= '0;
      pk_be    <= '0;
      pk_addr  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_nx;
      pk_data <= pk_data_nx;
      pk_be   <= pk_be_nx;
      pk_addr <= pk_addr_nx;
      rd_ptr  <= rd_ptr_nx;
      done    <= done_nx;
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage; a push into a full FIFO with a pop reuses the slot being popped
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr[AW-1:0]] <= push_data;
      mem_be[wr_ptr[AW-1:0]]   <= push_be;
      mem_addr[wr_ptr[AW-1:0]] <= push_addr;
    end
  end

  // Registered FIFO head; holds while stalled or empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_wren <= 1'b0;
      P_addr <= '0;
      P_din  <= '0;
      P_be   <= '0;
    end else begin
      P_wren <= head_valid;
      if (head_valid) begin
        P_addr <= {3'b000, mem_addr[head]};
        P_din  <= mem_data[head];
        P_be   <= mem_be[head];
      end
    end
  end

endmodule

// File: tb/tb_ofm_requant_packer.sv
// tb/tb_ofm_requant_packer.sv - self-checking bench for ofm_requant_packer; follows OFM_REQUANT_ROUND_EN
module tb_ofm_requant_packer;

  localparam int IW    = 25;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } word_t;

  typedef struct {
    longint     din;
    logic [7:0] exp_t;
    logic [7:0] exp_r;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          O_wren;
  logic [31:0]   O_ram_addr;
  logic [IW-1:0] O_ram_din;
  logic          end_conv;
  logic          P_wren;
  logic          P_ready;
  logic [31:0]   P_addr;
  logic [63:0]   P_din;
  logic [7:0]    P_be;
  logic          overflow;
  logic          done;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t got_q[$];
  word_t exp_q[$];
  int    popped_cnt = 0;
  int    pushed_cnt = 0;
  int    done_cnt   = 0;
  int    done_cyc   = 0;
  int    cyc        = 0;
  bit    stall_prev = 0;
  word_t stall_w;

  bit         m_valid;
  int         m_word;
  logic [7:0] m_bytes [8];
  logic [7:0] m_be;

  vec_t vecs [16];

  ofm_requant_packer #(.IW(IW), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .O_wren     (O_wren),
    .O_ram_addr (O_ram_addr),
    .O_ram_din  (O_ram_din),
    .end_conv   (end_conv),
    .P_wren     (P_wren),
    .P_ready    (P_ready),
    .P_addr     (P_addr),
    .P_din      (P_din),
    .P_be       (P_be),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference requantisation from plain integer arithmetic
  function automatic logic [7:0] ref_byte(input longint d);
    longint q;
    if (d < 0) return 8'd0;
`ifdef OFM_REQUANT_ROUND_EN
    q = (d + (longint'(1) << (SHIFT-1))) / (longint'(1) << SHIFT);
`else
    q = d / (longint'(1) << SHIFT);
`endif
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic logic [7:0] vec_exp(input vec_t v);
`ifdef OFM_REQUANT_ROUND_EN
    return v.exp_r;
`else
    return v.exp_t;
`endif
  endfunction

  task automatic model_emit();
    word_t w;
    w.addr = 32'(m_word);
    w.be   = m_be;
    w.data = '0;
    for (int k = 0; k < 8; k++) w.data[8*k +: 8] = m_bytes[k];
    exp_q.push_back(w);
    pushed_cnt++;
    m_valid = 0;
  endtask

  // A word is a run of samples sharing addr>>3; it leaves when all 8 lanes are seen or the run ends
  task automatic model_sample(input int addr, input longint d);
    if (m_valid && (addr >> 3) != m_word) model_emit();
    if (!m_valid) begin
      m_valid = 1;
      m_word  = addr >> 3;
      m_be    = '0;
    end
    m_bytes[addr & 7] = ref_byte(d);
    m_be[addr & 7]    = 1'b1;
    if (m_be == 8'hFF) model_emit();
  endtask

  task automatic model_flush();
    if (m_valid) model_emit();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int addr, input longint d);
    O_wren     = 1'b1;
    O_ram_addr = 32'(addr);
    O_ram_din  = d[IW-1:0];
    model_sample(addr, d);
    tick();
    O_wren = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    m_valid    = 0;
    pushed_cnt = 0;
    popped_cnt = 0;
  endtask

  task automatic get_word(input string nm, output word_t w);
    int t;
    t = 0;
    while (got_q.size() == 0 && t < 200) begin
      tick();
      t++;
    end
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no word within 200 cycles", nm);
      w = '0;
    end
  endtask

  task automatic cmp_word(input string nm, input word_t g, input logic [31:0] ea,
                          input logic [63:0] ed, input logic [7:0] eb);
    check({nm, "_addr"}, g.addr, ea);
    check({nm, "_be"}, g.be, eb);
    check({nm, "_data"}, g.data & be_mask(eb), ed & be_mask(eb));
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 300) begin
      tick();
      t++;
    end
    repeat (10) tick();
  endtask

  function automatic logic [63:0] pat(input int w);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(w*8 + k + 1);
    return d;
  endfunction

  // Transfer capture, done pulse counting and stall stability
  always @(negedge clk) begin
    cyc++;
    if (rst && P_wren && P_ready) begin
      got_q.push_back({P_addr, P_din, P_be});
      popped_cnt++;
    end
    if (rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_wren", P_wren, 1);
        check("stall_addr", P_addr, stall_w.addr);
        check("stall_data", P_din, stall_w.data);
        check("stall_be", P_be, stall_w.be);
      end
      stall_prev = P_wren && !P_ready;
      stall_w    = {P_addr, P_din, P_be};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    int    base, ec_cyc, cur_w, a, t;
    longint d;

    vecs[0]  = '{-1,        8'd0,   8'd0};
    vecs[1]  = '{-16777216, 8'd0,   8'd0};
    vecs[2]  = '{0,         8'd0,   8'd0};
    vecs[3]  = '{127,       8'd0,   8'd0};
    vecs[4]  = '{128,       8'd0,   8'd1};
    vecs[5]  = '{255,       8'd0,   8'd1};
    vecs[6]  = '{256,       8'd1,   8'd1};
    vecs[7]  = '{384,       8'd1,   8'd2};
    vecs[8]  = '{383,       8'd1,   8'd1};
    vecs[9]  = '{65279,     8'd254, 8'd255};
    vecs[10] = '{65280,     8'd255, 8'd255};
    vecs[11] = '{65407,     8'd255, 8'd255};
    vecs[12] = '{65408,     8'd255, 8'd255};
    vecs[13] = '{65536,     8'd255, 8'd255};
    vecs[14] = '{16777215,  8'd255, 8'd255};
    vecs[15] = '{1000,      8'd3,   8'd4};

    rst        = 1'b0;
    O_wren     = 1'b0;
    O_ram_addr = '0;
    O_ram_din  = '0;
    end_conv   = 1'b0;
    P_ready    = 1'b1;
    tick();
    tick();
    check("rst_P_wren", P_wren, 0);
    check("rst_P_addr", P_addr, 0);
    check("rst_P_din", P_din, 0);
    check("rst_P_be", P_be, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // full word, with exact output latency
    for (int l = 0; l < 8; l++) send(l, 384);
    @(negedge clk);
    check("s1_lat_n", P_wren, 0);
    @(negedge clk);
    check("s1_lat_n1", P_wren, 1);
    get_word("s1", w);
`ifdef OFM_REQUANT_ROUND_EN
    cmp_word("s1", w, 32'd0, 64'h0202020202020202, 8'hFF);
`else
    cmp_word("s1", w, 32'd0, 64'h0101010101010101, 8'hFF);
`endif

    // ReLU, saturation, partial word pushed by address change
    send(8, -1);
    send(9, 1048576);
    send(10, 512);
    send(24, 256);
    get_word("s2", w);
    cmp_word("s2", w, 32'd1, 64'h000000000002FF00, 8'h07);
    repeat (5) tick();
    check("s2_held", got_q.size(), 0);

    // flush and done
    base     = done_cnt;
    ec_cyc   = cyc + 1;
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    get_word("s3", w);
    cmp_word("s3", w, 32'd3, 64'h01, 8'h01);
    wait_done(base);
    check("s3_done_once", done_cnt - base, 1);
    check("s3_done_gap", (done_cyc - ec_cyc >= 2), 1);

    // table-driven requantisation vectors, two full words
    for (int i = 0; i < 16; i++) send(32'h200 + i, vecs[i].din);
    for (int wi = 0; wi < 2; wi++) begin
      get_word("tbl", w);
      check("tbl_addr", w.addr, 32'h40 + wi);
      check("tbl_be", w.be, 8'hFF);
      for (int k = 0; k < 8; k++)
        check($sformatf("tbl_vec%0d", wi*8 + k), w.data[8*k +: 8], vec_exp(vecs[wi*8 + k]));
    end

    // backpressure: fifth word lost, four delivered in order
    P_ready = 1'b0;
    for (int wi = 0; wi < 5; wi++) begin
      if (wi == 4) check("s4_no_ovf_4", overflow, 0);
      for (int l = 0; l < 8; l++) send(32'h100 + wi*8 + l, longint'((wi*8 + l + 1) * 256));
    end
    check("s4_ovf", overflow, 1);
    repeat (3) tick();
    P_ready = 1'b1;
    for (int wi = 0; wi < 4; wi++) begin
      get_word("s4", w);
      cmp_word($sformatf("s4_w%0d", wi), w, 32'h20 + wi, pat(wi), 8'hFF);
    end
    repeat (10) tick();
    check("s4_exactly4", got_q.size(), 0);

    // push into a full FIFO in the same cycle as a pop
    do_reset();
    P_ready = 1'b0;
    for (int wi = 5; wi < 10; wi++) begin
      for (int l = 0; l < 8; l++) begin
        if (wi == 9 && l == 7) P_ready = 1'b1;
        send(32'h100 + wi*8 + l, longint'((wi*8 + l + 1) * 256));
      end
    end
    check("s5_no_ovf", overflow, 0);
    for (int wi = 5; wi < 10; wi++) begin
      get_word("s5", w);
      cmp_word($sformatf("s5_w%0d", wi), w, 32'h20 + wi, pat(wi), 8'hFF);
    end

    // reset mid-stream
    P_ready = 1'b0;
    for (int l = 0; l < 8; l++) send(l, 384);
    repeat (2) tick();
    send(16, 1000);
    send(17, 2000);
    send(18, 3000);
    check("s6_pre_wren", P_wren, 1);
    rst = 1'b0;
    #1;
    check("s6_P_wren", P_wren, 0);
    check("s6_P_addr", P_addr, 0);
    check("s6_P_din", P_din, 0);
    check("s6_P_be", P_be, 0);
    check("s6_overflow", overflow, 0);
    check("s6_done", done, 0);
    tick();
    rst     = 1'b1;
    P_ready = 1'b1;
    tick();
    got_q.delete();
    for (int l = 0; l < 8; l++) send(l, 256);
    get_word("s6", w);
    cmp_word("s6", w, 32'd0, 64'h0101010101010101, 8'hFF);
    repeat (10) tick();
    check("s6_single", got_q.size(), 0);

    // randomized traffic against the reference model
    do_reset();
    cur_w = 0;
    for (int c = 0; c < 800; c++) begin
      P_ready = ($urandom_range(0, 3) != 0);
      if ((pushed_cnt - popped_cnt) <= 2 && $urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 9) < 3) cur_w = $urandom_range(0, 15);
        a = cur_w*8 + $urandom_range(0, 7);
        case ($urandom_range(0, 3))
          0:       d = 0 - longint'($urandom_range(1, 16777216));
          1:       d = longint'($urandom_range(0, 1023));
          2:       d = longint'($urandom_range(0, 70000));
          default: d = longint'($urandom_range(0, 16777215));
        endcase
        send(a, d);
      end else begin
        tick();
      end
    end
    P_ready = 1'b1;
    t = 0;
    while ((pushed_cnt - popped_cnt) > 1 && t < 100) begin
      tick();
      t++;
    end
    // last sample and end_conv together: sample packed, then flushed
    base       = done_cnt;
    O_wren     = 1'b1;
    end_conv   = 1'b1;
    O_ram_addr = 32'(cur_w*8 + 8 + 3);
    O_ram_din  = 25'd77777;
    model_sample(cur_w*8 + 8 + 3, 77777);
    model_flush();
    tick();
    O_wren   = 1'b0;
    end_conv = 1'b0;
    wait_done(base);
    check("rand_done", done_cnt - base, 1);
    check("rand_ovf", overflow, 0);
    check("rand_count", got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      word_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      cmp_word("rand", g, e.addr, e.data, e.be);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
